// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: size encodings, FSM state type and lane-mask helpers shared by
// the load/store master and its alignment datapath.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_DONE   = 3'd5
  } lsu_state_e;

  // Byte-enable pattern of an access of the given size, before lane shifting.
  function automatic logic [3:0] sizemask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'h1;
      SZ_H:    return 4'h3;
      SZ_W:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // Number of bytes touched; the illegal encoding reports 1 so it never
  // looks misaligned (it is rejected separately).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane datapath. Shifts store data/strobes onto
// the byte lanes of a two-word window and realigns/extends load data taken
// from the same window.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [3:0]  wstrb_lo,
  output logic [3:0]  wstrb_hi,
  output logic [31:0] rdata_ext
);

  logic [63:0] wshift;
  logic [7:0]  wmask;
  logic [31:0] rshift;

  // Store side: place right-aligned data and its byte mask at the byte offset.
  always_comb begin
    wshift   = {32'b0, wdata} << {off, 3'b000};
    wmask    = {4'b0, sizemask(size)} << off;
    wdata_lo = wshift[31:0];
    wdata_hi = wshift[63:32];
    wstrb_lo = wmask[3:0];
    wstrb_hi = wmask[7:4];
  end

  // Load side: pull the addressed bytes down to bit 0, then extend to 32 bits.
  always_comb begin
    rshift = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (size)
      SZ_B:    rdata_ext = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
      SZ_H:    rdata_ext = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/mem_lsu_master.sv
// mem_lsu_master: turns core byte/half/word load/store requests into
// word-granular dmem read/write transactions. All dmem_* and resp_* outputs
// come straight from flops.
// Build option: define MISALIGNED_SPLIT_EN to split accesses that cross a
// word boundary into two word transactions; otherwise they complete with
// resp_err and no dmem activity.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for a request
// ST_ISSUE0 | dmem strobe for word A = addr[31:2]
// ST_WAIT0  | load waiting for rresp of word A
// ST_ISSUE1 | dmem strobe for word A+1 (split builds only)
// ST_WAIT1  | load waiting for rresp of word A+1 (split builds only)
// ST_DONE   | resp_valid pulse
module mem_lsu_master
  import mem_lsu_pkg::*;
#(
  parameter int RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        dmem_rready,
  output logic [29:0] dmem_raddr,
  input  logic        dmem_rresp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wready,
  output logic [29:0] dmem_waddr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb
);

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic        err_q, err_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic        rready_q, rready_d;
  logic        wready_q, wready_d;
  logic [29:0] raddr_q, raddr_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdout_q, wdout_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  span;
  logic        misalign;
  logic        timeout_hit;
  logic        issue_d;
  logic        second_d;
  logic [29:0] word_a;
  logic [29:0] cur_word;
  logic [31:0] al_wdata_lo, al_wdata_hi, al_rdata;
  logic [3:0]  al_wstrb_lo, al_wstrb_hi;

  assign req_ready   = (state_q == ST_IDLE);
  assign span        = {1'b0, req_addr[1:0]} + size_bytes(req_size);
  assign misalign    = (span > 3'd4);
  // The down-counter is loaded on entry to a wait state; reaching 1 while
  // still waiting means the budget is used up.
  assign timeout_hit = (RESP_TIMEOUT > 0) && (tmr_q == TW'(1));

  mem_lsu_align u_align (
    .off       (addr_d[1:0]),
    .size      (size_d),
    .sign_ext  (signed_d),
    .wdata     (wdata_d),
    .rdata_lo  (lo_d),
    .rdata_hi  (hi_d),
    .wdata_lo  (al_wdata_lo),
    .wdata_hi  (al_wdata_hi),
    .wstrb_lo  (al_wstrb_lo),
    .wstrb_hi  (al_wstrb_hi),
    .rdata_ext (al_rdata)
  );

  // Sequencer: request latch, state transitions, read capture and timeout.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    split_d  = split_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    tmr_d    = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          lo_d     = '0;
          hi_d     = '0;
          split_d  = misalign && SPLIT_EN;
          if ((req_size == SZ_ILL) || (misalign && !SPLIT_EN)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE0;
          end
        end
      end
      ST_ISSUE0: begin
        if (!we_q) begin
          tmr_d   = TW'(RESP_TIMEOUT);
          state_d = ST_WAIT0;
        end else begin
          state_d = split_q ? ST_ISSUE1 : ST_DONE;
        end
      end
      ST_WAIT0: begin
        if (dmem_rresp) begin
          lo_d    = dmem_rdata;
          state_d = split_q ? ST_ISSUE1 : ST_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (RESP_TIMEOUT > 0) begin
          tmr_d = tmr_q - TW'(1);
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_ISSUE1: begin
        if (!we_q) begin
          tmr_d   = TW'(RESP_TIMEOUT);
          state_d = ST_WAIT1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT1: begin
        if (dmem_rresp) begin
          hi_d    = dmem_rdata;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (RESP_TIMEOUT > 0) begin
          tmr_d = tmr_q - TW'(1);
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output flops are loaded from the state being entered, so each strobe or
  // response lines up with its state cycle.
  always_comb begin
    issue_d  = (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1);
    second_d = (state_d == ST_ISSUE1);
    word_a   = addr_d[31:2];
    cur_word = second_d ? (word_a + 30'd1) : word_a;
    rready_d = issue_d && !we_d;
    wready_d = issue_d && we_d;
    raddr_d  = rready_d ? cur_word : '0;
    waddr_d  = wready_d ? cur_word : '0;
    wdout_d  = wready_d ? (second_d ? al_wdata_hi : al_wdata_lo) : '0;
    wstrb_d  = wready_d ? (second_d ? al_wstrb_hi : al_wstrb_lo) : '0;
    rvalid_d = (state_d == ST_DONE);
    rerr_d   = (state_d == ST_DONE) && err_d;
    rdata_d  = ((state_d == ST_DONE) && !err_d && !we_d) ? al_rdata : '0;
  end

  // State and request registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      split_q  <= split_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      tmr_q    <= tmr_d;
    end
  end

  // Registered dmem and response outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rready_q <= 1'b0;
      wready_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdout_q  <= '0;
      wstrb_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rready_q <= rready_d;
      wready_q <= wready_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdout_q  <= wdout_d;
      wstrb_q  <= wstrb_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dmem_rready = rready_q;
  assign dmem_wready = wready_q;
  assign dmem_raddr  = raddr_q;
  assign dmem_waddr  = waddr_q;
  assign dmem_wdata  = wdout_q;
  assign dmem_wstrb  = wstrb_q;
  assign resp_valid  = rvalid_q;
  assign resp_err    = rerr_q;
  assign resp_rdata  = rdata_q;

endmodule

// File: doc/mem_lsu_master.md
Name: mem_lsu_master

Overview:
- Initiator side of the data-memory port: turns core load/store requests (byte/half/word, any address) into the word-granular memory port protocol.
- Memory side: rready/raddr to rresp/rdata reads with 1-cycle latency; wready/waddr/wdata/wstrb writes that commit in the same cycle.
- Generates strobes and lane-shifted write data, sign/zero-extends read data, and optionally splits misaligned accesses into two word transactions.
- Sits between the core's execute/mem stage and the data RAM.

Parameters:
- RESP_TIMEOUT, 0, cycles to wait for rresp before flagging resp_err; 0 = wait forever.

Ports:
- clk  input  1  clock
- resetb  input  1  asynchronous active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  block can accept a request (IDLE)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  input  1  sign-extend load result
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  valid with resp_valid; illegal size, unsupported misalign or timeout
- resp_rdata  output  32  extended load data; 0 for stores and errors
- dmem_rready  output  1  read request
- dmem_raddr  output  30  read word address [31:2]
- dmem_rresp  input  1  read data valid
- dmem_rdata  input  32  read data, little-endian lanes
- dmem_wready  output  1  write strobe
- dmem_waddr  output  30  write word address [31:2]
- dmem_wdata  output  32  lane-aligned write data
- dmem_wstrb  output  4  byte enables

Behaviour:
- Reset (async, resetb low): state IDLE. req_ready=1. All other outputs 0. Latched request and read buffers cleared.
- Clock and reset: one clock (clk); reset is asynchronous, active-low (resetb).
- All dmem_* and resp_* outputs are registered.
- Offset and span: o = addr[1:0]; span = o + bytes(size). span > 4 means misaligned.
- Write lanes: 64-bit shifted data = {32'b0, wdata} << 8*o; 8-bit mask = sizemask << o, with sizemask 0x1/0x3/0xF. The low word uses bits [31:0] and mask [3:0]; the high word uses [63:32] and [7:4].
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - Illegal size, or misaligned without the feature, goes to DONE with err.
    - Otherwise go to ISSUE0.
  - ISSUE0: pulse rready (load) or wready (store) for word A = addr[31:2].
    - Load goes to WAIT0.
    - Store goes to ISSUE1 if split, else DONE.
  - WAIT0: on rresp, capture lo = rdata, then go to ISSUE1 if split, else DONE.
  - ISSUE1: access word A+1, mod 2^30 (wraps 0x3FFFFFFF to 0).
    - Load goes to WAIT1.
    - Store goes to DONE.
  - WAIT1: on rresp, capture hi, then go to DONE.
  - DONE: resp_valid=1 for one cycle, then go to IDLE.
- In WAITx without rresp: stay in the state. If RESP_TIMEOUT>0 and the counter reaches it, go to DONE with err.
- Load result: ({hi,lo} >> 8*o) truncated to size, then sign-extended if req_signed, else zero-extended.
- Latency from acceptance cycle T to resp_valid:
  - aligned load: T+3
  - aligned store: T+2
  - split load: T+5
  - split store: T+3
  - error: T+1
- Back-to-back: a new request is accepted only in IDLE. There is no overlap.
- Reset mid-operation: aborts immediately, with no response. For a split store, the first word may already be written; this is accepted behaviour.
- Never asserts rready and wready in the same cycle.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: misaligned half/word accesses are split into two word transactions as above.
- Undefined: misaligned requests get resp_err=1 at T+1 with no dmem activity. States ISSUE1 and WAIT1 are not built.

Decomposition:
- Package mem_lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state enum, sizemask function.
- One sub-module, mem_lsu_align (combinational):
  - write lane shift and strobe generation
  - read realign and extension

Test Plan:
Memory is preloaded with 0x100 = 0x88776655 and 0x104 = 0xCCBBAA99.
1. LB signed at 0x103 -> one rready, raddr 0x040; resp_rdata 0xFFFFFF88 at T+3, err 0.
2. LHU at 0x102 -> resp_rdata 0x00008877; then LW at 0x104 -> 0xCCBBAA99 at T+3.
3. SW 0xDEADBEEF at 0x100 -> single wready, waddr 0x040, wstrb 0xF, resp at T+2; a following LW at 0x100 returns 0xDEADBEEF.
4. LW at 0x103:
   - with MISALIGNED_SPLIT_EN: reads of 0x040 then 0x041, resp_rdata 0xBBAA9988 at T+5.
   - without it: resp_err=1 at T+1, no rready.
5. SH 0x1234 at 0x103 with the EN macro -> wstrb 0x8 at waddr 0x040 (wdata byte3 = 0x34), then wstrb 0x1 at 0x041 (byte0 = 0x12); resp at T+3; word 0x104 reads back 0xCCBBAA12.
6. resetb low during WAIT0 -> all outputs 0 asynchronously, no resp_valid; after release req_ready=1, and a new LB at 0x100 returns 0x00000055.
